// File: rtl/hyper_pipeline_receiver_if.sv
// Receiver-side bundle of the link: incoming words, the stall request returned to the sender,
// and the downstream valid/ready stream with status.
interface hyper_pipeline_receiver_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
);
    logic                     din_valid;
    logic [WIDTH-1:0]         din;
    logic                     din_stall;
    logic                     dout_valid;
    logic [WIDTH-1:0]         dout;
    logic                     dout_ready;
    logic [$clog2(DEPTH):0]   occupancy;
    logic                     overflow;

    // Sender and downstream-consumer side.
    modport master (
        output din_valid, din, dout_ready,
        input  din_stall, dout_valid, dout, occupancy, overflow
    );

    // Receiver side.
    modport slave (
        input  din_valid, din, dout_ready,
        output din_stall, dout_valid, dout, occupancy, overflow
    );
endinterface

// File: rtl/hyper_pipeline_receiver.sv
// Far-end receiver of a register-only link: a skid FIFO with registered first-word-fall-through output
// and a registered stall request sized so that words still in flight always find room.
module hyper_pipeline_receiver #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int DEPTH  = 16
) (
    input  logic                     ap_clk,
    input  logic                     areset,
    hyper_pipeline_receiver_if.slave bus
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int OCC_W  = PTR_W + 1;
    localparam int SKID   = 2 * STAGES + 1;
    localparam int THRESH = DEPTH - SKID;

    generate
        if (DEPTH < 2 * STAGES + 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("hyper_pipeline_receiver: DEPTH must be a power of two and >= 2*STAGES+2");
        end
    endgenerate

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             stall_q, stall_d;
    logic             overflow_q, overflow_d;
    logic             full, push, pop;

    // NOTE: every signal gets a default at the top of the block so no path leaves one unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        full       = (occ_q == OCC_W'(DEPTH));
        pop        = dout_valid_q && bus.dout_ready;
        push       = bus.din_valid && (!full || pop);

        wr_ptr_d   = wr_ptr_q + PTR_W'(push);
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
        occ_d      = occ_q;
        overflow_d = overflow_q | (bus.din_valid && full && !pop);
        dout_d     = dout_q;

        case ({push, pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase

        // Next head is the incoming word only when nothing older survives this cycle.
        if ((occ_q - OCC_W'(pop)) == '0) begin
            if (push) dout_d = bus.din;
        end else begin
            dout_d = mem[rd_ptr_d];
        end

        dout_valid_d = (occ_d != '0);
        stall_d      = (occ_d >= OCC_W'(THRESH));
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge ap_clk or negedge areset) begin
        if (!areset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            occ_q        <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            stall_q      <= 1'b1;
            overflow_q   <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            occ_q        <= occ_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            stall_q      <= stall_d;
            overflow_q   <= overflow_d;
        end
    end

    // NOTE: storage is deliberately left without reset; occupancy decides which entries are meaningful.
    always_ff @(posedge ap_clk) begin
        if (push) mem[wr_ptr_q] <= bus.din;
    end

    assign bus.din_stall  = stall_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.dout       = dout_q;
    assign bus.occupancy  = occ_q;
    assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_hyper_pipeline_receiver.sv
// Directed bench for hyper_pipeline_receiver: a queue scoreboard predicts every popped word,
// occupancy, stall and overflow cycle by cycle.
module tb_hyper_pipeline_receiver;
    localparam int W  = 32;
    localparam int D  = 16;
    localparam int TH = 11;

    logic ap_clk = 1'b0;
    logic areset = 1'b0;
    always #5 ap_clk = ~ap_clk;

    hyper_pipeline_receiver_if #(.WIDTH(W), .DEPTH(D)) bus ();

    hyper_pipeline_receiver #(.WIDTH(W), .STAGES(2), .DEPTH(D)) dut (
        .ap_clk (ap_clk),
        .areset (areset),
        .bus    (bus.slave)
    );

    int         checks   = 0;
    int         failures = 0;
    logic [W-1:0] exp_q[$];
    logic       ovf_m = 1'b0;
    int         peak  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs are already driven; predict this edge, advance, then check post-edge state.
    task automatic tick();
        logic pop_m, push_m;
        pop_m  = bus.dout_ready && (exp_q.size() > 0);
        push_m = bus.din_valid && ((exp_q.size() < D) || pop_m);
        if (bus.din_valid && exp_q.size() == D && !pop_m) ovf_m = 1'b1;
        if (pop_m) begin
            check("dout", {32'h0, bus.dout}, {32'h0, exp_q[0]});
            void'(exp_q.pop_front());
        end
        if (push_m) exp_q.push_back(bus.din);
        if (exp_q.size() > peak) peak = exp_q.size();
        @(posedge ap_clk);
        #1;
        check("occupancy",  64'(bus.occupancy), 64'(exp_q.size()));
        check("dout_valid", 64'(bus.dout_valid), 64'(exp_q.size() > 0));
        check("din_stall",  64'(bus.din_stall), 64'(exp_q.size() >= TH));
        check("overflow",   64'(bus.overflow), 64'(ovf_m));
    endtask

    initial begin
        logic         sl [2];
        logic         dv_l [2];
        logic [W-1:0] dd_l [2];
        logic         snd_stall;
        int           sent;
        int           cyc;
        int           pushed;

        bus.din_valid  = 1'b0;
        bus.din        = '0;
        bus.dout_ready = 1'b0;

        // Reset state, then first edge after release computes stall.
        repeat (2) @(posedge ap_clk);
        #1;
        check("rst_stall",      64'(bus.din_stall), 64'd1);
        check("rst_occupancy",  64'(bus.occupancy), 64'd0);
        check("rst_dout_valid", 64'(bus.dout_valid), 64'd0);
        check("rst_overflow",   64'(bus.overflow), 64'd0);
        check("rst_dout",       64'(bus.dout), 64'd0);
        areset = 1'b1;
        tick();

        // Pass-through with consumer always ready.
        bus.dout_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.din_valid = 1'b1;
            bus.din       = W'(32'hA0 + i);
            tick();
        end
        bus.din_valid = 1'b0;
        tick();
        tick();
        check("passthru_peak", 64'(peak), 64'd1);

        // Sender behind a 2-register forward and 2-register return line, honouring stall.
        sl[0] = 1'b0; sl[1] = 1'b0;
        dv_l[0] = 1'b0; dv_l[1] = 1'b0;
        dd_l[0] = '0; dd_l[1] = '0;
        sent = 0;
        cyc  = 0;
        peak = 0;
        do begin
            snd_stall = sl[1];
            sl[1]     = sl[0];
            sl[0]     = bus.din_stall;
            dv_l[1]   = dv_l[0];
            dd_l[1]   = dd_l[0];
            dv_l[0]   = !snd_stall && (sent < 30);
            dd_l[0]   = W'(32'h100 + sent);
            if (dv_l[0]) sent++;
            bus.din_valid  = dv_l[1];
            bus.din        = dd_l[1];
            bus.dout_ready = (cyc >= 25);
            tick();
            cyc++;
        end while (cyc < 300 && (sent < 30 || dv_l[0] || dv_l[1] || exp_q.size() > 0));
        bus.din_valid = 1'b0;
        check("stream_sent",    64'(sent), 64'd30);
        check("stream_drained", 64'(exp_q.size()), 64'd0);
        check("stream_peak_ok", 64'(peak <= D), 64'd1);
        check("stream_stalled", 64'(peak >= TH), 64'd1);

        // Fill to full, then push with a simultaneous pop.
        bus.dout_ready = 1'b0;
        for (int i = 0; i < D; i++) begin
            bus.din_valid = 1'b1;
            bus.din       = W'(32'h200 + i);
            tick();
        end
        bus.din        = W'(32'hDEAD);
        bus.dout_ready = 1'b1;
        tick();

        // Full with no pop: word is dropped and overflow becomes sticky.
        bus.dout_ready = 1'b0;
        bus.din        = W'(32'hBEEF);
        tick();
        bus.din_valid  = 1'b0;
        tick();
        bus.dout_ready = 1'b1;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 40) begin
            tick();
            cyc++;
        end
        check("full_drained", 64'(exp_q.size()), 64'd0);

        // Random consumer, sender honouring stall directly; wraps the pointers.
        pushed = 0;
        cyc    = 0;
        while (pushed < 40 && cyc < 400) begin
            bus.dout_ready = ($urandom_range(0, 1) == 1);
            bus.din_valid  = !bus.din_stall && ($urandom_range(0, 3) != 0);
            bus.din        = W'(32'h300 + pushed);
            if (bus.din_valid) pushed++;
            tick();
            cyc++;
        end
        check("random_pushed", 64'(pushed), 64'd40);

        // Leave words inside, then reset mid-cycle.
        bus.dout_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.din_valid = 1'b1;
            bus.din       = W'(32'h400 + i);
            tick();
        end
        bus.din_valid = 1'b0;
        #2;
        areset = 1'b0;
        #1;
        check("midrst_occupancy",  64'(bus.occupancy), 64'd0);
        check("midrst_dout_valid", 64'(bus.dout_valid), 64'd0);
        check("midrst_stall",      64'(bus.din_stall), 64'd1);
        check("midrst_overflow",   64'(bus.overflow), 64'd0);
        exp_q.delete();
        ovf_m = 1'b0;
        @(posedge ap_clk);
        #1;
        areset = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
